// File: rtl/cpu_mem_arbiter.sv
// Two-requester arbiter (R0 = fetch, R1 = load/store) in front of the single data-side bus wrapper.
// R1 wins by default; an aging counter forces R0 through, and a sticky watchdog flags hung transfers.
module cpu_mem_arbiter #(
    parameter int MAX_WAIT = 2,
    parameter int TIMEOUT  = 256
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic        r0_oe,
    input  logic [3:0]  r0_web,
    input  logic [31:0] r0_addr,
    input  logic [31:0] r0_wdata,
    output logic [31:0] r0_rdata,
    output logic        r0_done,
    input  logic        r1_oe,
    input  logic [3:0]  r1_web,
    input  logic [31:0] r1_addr,
    input  logic [31:0] r1_wdata,
    output logic [31:0] r1_rdata,
    output logic        r1_done,
    output logic        m_oe,
    output logic [3:0]  m_web,
    output logic [31:0] m_addr,
    output logic [31:0] m_di,
    output logic        m_stall,
    input  logic [31:0] m_data,
    input  logic        m_done,
    output logic        grant,
    output logic        busy,
    output logic        timeout_err
);

    localparam logic [3:0]  MAX_W   = 4'(MAX_WAIT);
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_req_oe;
    logic [3:0]  r_m_web;
    logic [31:0] r_m_addr;
    logic [31:0] r_m_di;
    logic        r_grant;
    logic [3:0]  r_age_cnt;
    logic [15:0] r_wd_cnt;
    logic        r_timeout_err;
    logic [31:0] r_r0_rdata;
    logic [31:0] r_r1_rdata;

    logic        w_p0;
    logic        w_p1;
    logic        w_pick0;
    logic        w_done;
    logic [31:0] w_ret;

    assign w_p0    = r0_oe | (r0_web != 4'hF);
    assign w_p1    = r1_oe | (r1_web != 4'hF);
    assign w_pick0 = w_p0 & (~w_p1 | (r_age_cnt >= MAX_W));
    assign w_done  = (r_state == S_WAIT) & m_done;
    // Writes return zero data so a stale read value never looks like store feedback.
    assign w_ret   = (r_m_web != 4'hF) ? 32'h0 : m_data;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        m_oe        = 1'b0;
        m_web       = 4'hF;
        m_stall     = 1'b1;
        busy        = (r_state != S_IDLE);
        m_addr      = r_m_addr;
        m_di        = r_m_di;
        grant       = r_grant;
        timeout_err = r_timeout_err;
        r0_done     = w_done & ~r_grant;
        r1_done     = w_done & r_grant;
        r0_rdata    = r0_done ? w_ret : r_r0_rdata;
        r1_rdata    = r1_done ? w_ret : r_r1_rdata;
        case (r_state)
            S_IDLE: begin
                if (w_p0 || w_p1) w_next = S_ISSUE;
            end
            S_ISSUE: begin
                m_stall = 1'b0;
                m_oe    = r_req_oe;
                m_web   = r_m_web;
                w_next  = S_WAIT;
            end
            S_WAIT: begin
                if (m_done) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_req_oe      <= 1'b0;
            r_m_web       <= 4'hF;
            r_m_addr      <= 32'h0;
            r_m_di        <= 32'h0;
            r_grant       <= 1'b1;
            r_age_cnt     <= 4'h0;
            r_wd_cnt      <= 16'h0;
            r_timeout_err <= 1'b0;
            r_r0_rdata    <= 32'h0;
            r_r1_rdata    <= 32'h0;
        end else begin
            if (r_state == S_IDLE && (w_p0 || w_p1)) begin
                r_grant <= ~w_pick0;
                if (w_pick0) begin
                    r_req_oe  <= r0_oe & (r0_web == 4'hF);
                    r_m_web   <= r0_web;
                    r_m_addr  <= r0_addr;
                    r_m_di    <= r0_wdata;
                    r_age_cnt <= 4'h0;
                end else begin
                    r_req_oe <= r1_oe & (r1_web == 4'hF);
                    r_m_web  <= r1_web;
                    r_m_addr <= r1_addr;
                    r_m_di   <= r1_wdata;
                    if (w_p0 && r_age_cnt != 4'hF) r_age_cnt <= r_age_cnt + 4'h1;
                end
            end
            if (w_done) begin
                if (r_grant) r_r1_rdata <= w_ret;
                else         r_r0_rdata <= w_ret;
            end
            // The watchdog only reports; the transfer keeps waiting for m_done.
            if (r_state == S_WAIT && !m_done) begin
                if (r_wd_cnt != 16'hFFFF) r_wd_cnt <= r_wd_cnt + 16'h1;
                if (r_wd_cnt == WD_LAST)  r_timeout_err <= 1'b1;
            end else begin
                r_wd_cnt <= 16'h0;
            end
        end
    end

endmodule
